// File: rtl/fixed_point_unsigned_long_divider.sv
// Unsigned Q(WIDTH-FRAC).FRAC restoring divider, one quotient bit per clock,
// start/ready handshake in, one-cycle valid pulse out, saturating quotient.
module fixed_point_unsigned_long_divider #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     num_q, num_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   rem_shift, rem_next;
  logic [N-1:0]     quo_next;
  logic             ge, ovf_next;

  // One restoring step: bring down the next numerator bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], num_q[N-1]};
    ge        = rem_shift >= {1'b0, div_q};
    rem_next  = ge ? (rem_shift - {1'b0, div_q}) : rem_shift;
    quo_next  = {quo_q[N-2:0], ge};
    ovf_next  = |(quo_next >> WIDTH);
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_divisor != '0) begin
            div_d   = i_divisor;
            num_d   = N'(i_dividend) << FRAC;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            state_d     = S_DONE;
          end
        end
      end
      S_BUSY: begin
        num_d = num_q << 1;
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // Results are captured straight from the final step's combinational values.
          quotient_d  = ovf_next ? '1 : quo_next[WIDTH-1:0];
          remainder_d = rem_next[WIDTH-1:0];
          dbz_d       = 1'b0;
          ovf_d       = ovf_next;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_valid       = (state_q == S_DONE);
  assign o_quotient    = quotient_q;
  assign o_remainder   = remainder_q;
  assign o_div_by_zero = dbz_q;
  assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_fixed_point_unsigned_long_divider.sv
// Self-checking bench: directed cases plus random operands against an
// arithmetic reference (integer divide / modulo with saturation).
module tb_fixed_point_unsigned_long_divider;
  localparam int W = 8;
  localparam int F = 4;
  localparam int N = W + F;

  logic         gclk = 1'b0;
  logic         i_reset, i_start;
  logic [W-1:0] i_dividend, i_divisor;
  logic         o_ready, o_valid, o_div_by_zero, o_overflow;
  logic [W-1:0] o_quotient, o_remainder;

  int n_tests = 0;
  int n_fail  = 0;

  fixed_point_unsigned_long_divider #(.WIDTH(W), .FRAC(F)) dut (
    .i_clk(gclk), .i_reset(i_reset), .i_start(i_start),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_ready(o_ready), .o_valid(o_valid), .o_quotient(o_quotient),
    .o_remainder(o_remainder), .o_div_by_zero(o_div_by_zero),
    .o_overflow(o_overflow)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: true quotient of (dd * 2^F) / dv, saturated to W bits.
  task automatic model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                       output longint q, output longint r,
                       output bit dbz, output bit ovf);
    longint unsigned num, full, maxq;
    num  = longint'(dd) * (longint'(1) << F);
    maxq = (longint'(1) << W) - 1;
    if (dv == 0) begin
      q = maxq; r = 0; dbz = 1; ovf = 0;
    end else begin
      full = num / dv;
      r    = num % dv;
      dbz  = 0;
      ovf  = full > maxq;
      q    = ovf ? maxq : full;
    end
  endtask

  // Waits for o_valid starting from cycle 'start_cyc'; returns the cycle it was seen in.
  task automatic wait_valid(input int start_cyc, input bit noise, output int lat);
    lat = start_cyc;
    while (!o_valid && lat < start_cyc + 60) begin
      if (noise) begin
        i_start    = 1'($urandom);
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
      end
      @(negedge gclk);
      lat++;
    end
    i_start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] dd,
                              input logic [W-1:0] dv, input int lat);
    longint q, r;
    bit dbz, ovf;
    model(dd, dv, q, r, dbz, ovf);
    chk({tag, ".valid"},   longint'(o_valid), 1);
    chk({tag, ".latency"}, longint'(lat), (dv == 0) ? 1 : N + 1);
    chk({tag, ".ready_lo"}, longint'(o_ready), 0);
    chk({tag, ".quot"},    longint'(o_quotient), q);
    chk({tag, ".rem"},     longint'(o_remainder), r);
    chk({tag, ".dbz"},     longint'(o_div_by_zero), longint'(dbz));
    chk({tag, ".ovf"},     longint'(o_overflow), longint'(ovf));
    @(negedge gclk);
    chk({tag, ".ready_hi"}, longint'(o_ready), 1);
    chk({tag, ".pulse"},   longint'(o_valid), 0);
    chk({tag, ".hold_q"},  longint'(o_quotient), q);
  endtask

  // Caller is at a negedge in IDLE; this is accept cycle 0.
  task automatic do_op(input string tag, input logic [W-1:0] dd,
                       input logic [W-1:0] dv, input bit noise);
    int lat;
    chk({tag, ".ready_in"}, longint'(o_ready), 1);
    i_start = 1'b1; i_dividend = dd; i_divisor = dv;
    @(negedge gclk);
    i_start = 1'b0; i_dividend = W'($urandom); i_divisor = W'($urandom);
    wait_valid(1, noise, lat);
    check_result(tag, dd, dv, lat);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_valid) seen++;
      @(negedge gclk);
    end
    chk({tag, ".no_extra_valid"}, longint'(seen), 0);
  endtask

  initial begin
    int lat;
    i_reset = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(negedge gclk);
    i_reset = 1'b0;
    chk("rst.ready", longint'(o_ready), 1);
    chk("rst.valid", longint'(o_valid), 0);
    chk("rst.quot",  longint'(o_quotient), 0);
    chk("rst.rem",   longint'(o_remainder), 0);
    chk("rst.flags", longint'({o_div_by_zero, o_overflow}), 0);

    do_op("3_div_2",   8'h30, 8'h20, 0);
    chk("3_div_2.exact", longint'(o_quotient), 8'h18);
    do_op("1_div_3",   8'h10, 8'h30, 0);
    chk("1_div_3.exact_q", longint'(o_quotient), 8'h05);
    chk("1_div_3.exact_r", longint'(o_remainder), 8'h10);
    do_op("sat",       8'hFF, 8'h01, 0);
    chk("sat.exact_ovf", longint'(o_overflow), 1);
    do_op("dbz",       8'h40, 8'h00, 0);
    chk("dbz.exact", longint'(o_div_by_zero), 1);
    do_op("zero_dd",   8'h00, 8'h37, 0);
    do_op("max_max",   8'hFF, 8'hFF, 0);

    // Start during BUSY must be ignored and must not disturb latched operands.
    i_start = 1'b1; i_dividend = 8'h30; i_divisor = 8'h20;
    @(negedge gclk);
    i_start = 1'b0;
    repeat (3) @(negedge gclk);
    i_start = 1'b1; i_dividend = 8'h10; i_divisor = 8'h30;
    @(negedge gclk);
    i_start = 1'b0; i_dividend = 8'hA5; i_divisor = 8'h00;
    wait_valid(5, 0, lat);
    check_result("ignore_start", 8'h30, 8'h20, lat);
    watch_no_valid("ignore_start", 20);

    // Reset in cycle 5 aborts the in-flight division.
    i_start = 1'b1; i_dividend = 8'h30; i_divisor = 8'h20;
    @(negedge gclk);
    i_start = 1'b0;
    repeat (4) @(negedge gclk);
    i_reset = 1'b1;
    @(negedge gclk);
    i_reset = 1'b0;
    chk("abort.ready", longint'(o_ready), 1);
    chk("abort.valid", longint'(o_valid), 0);
    chk("abort.quot",  longint'(o_quotient), 0);
    chk("abort.rem",   longint'(o_remainder), 0);
    chk("abort.flags", longint'({o_div_by_zero, o_overflow}), 0);
    watch_no_valid("abort", 20);
    do_op("after_abort", 8'h10, 8'h30, 0);

    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] dd, dv;
      dd = W'($urandom);
      dv = ($urandom_range(0, 9) == 0) ? '0 :
           ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 4)) : W'($urandom);
      do_op($sformatf("rnd%0d", k), dd, dv, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fixed_point_unsigned_long_divider.md
Name: fixed_point_unsigned_long_divider

Overview:
- Parametrised, handshaked sequential successor to the simple 8-bit fixed-point unsigned long divider.
- Divides two unsigned Q(WIDTH-FRAC).FRAC operands using restoring long division, one quotient bit per clock.
- Produces a same-format quotient with saturation, plus the integer remainder and divide-by-zero/overflow flags.
- Sits in the DSP filter datapath wherever normalisation or gain division is needed, fed by a start/ready handshake.

Parameters:
- WIDTH, 8, operand and quotient width in bits; legal values are WIDTH >= 2.
- FRAC, 4, fractional bits shared by dividend, divisor and quotient; legal values are 0 <= FRAC < WIDTH.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request; accepted only when o_ready=1.
- i_dividend  in  WIDTH  unsigned Q(WIDTH-FRAC).FRAC dividend; sampled on accept.
- i_divisor  in  WIDTH  unsigned Q(WIDTH-FRAC).FRAC divisor; sampled on accept.
- o_ready  out  1  high in IDLE only.
- o_valid  out  1  one-cycle pulse; result outputs valid.
- o_quotient  out  WIDTH  saturated Q(WIDTH-FRAC).FRAC quotient.
- o_remainder  out  WIDTH  (dividend<<FRAC) mod divisor.
- o_div_by_zero  out  1  divisor was zero.
- o_overflow  out  1  true quotient exceeded 2^WIDTH-1 and was saturated.

Behaviour:
- One clock domain; synchronous active-high reset.
- Reset action: state goes to IDLE. o_valid, o_quotient, o_remainder, o_div_by_zero and o_overflow are all cleared to 0. o_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the division. No o_valid is produced for the aborted operation.
- Define N = WIDTH+FRAC. The numerator register is N bits, loaded with {i_dividend, FRAC zeros}.
- The partial remainder is WIDTH+1 bits; the quotient accumulator is N bits. The iteration counter counts N steps.
- State IDLE:
  - o_ready=1.
  - If i_start=1 and i_divisor!=0: latch operands, clear remainder and quotient, go to BUSY.
  - If i_start=1 and i_divisor==0: go to DONE with the zero-divisor result.
- State BUSY, one step per cycle:
  - rem = {rem[WIDTH-1:0], num MSB}; shift num left by 1.
  - If rem >= divisor: rem -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - The quotient shifts left with the new bit in the LSB.
  - After the N-th step, go to DONE.
- State DONE:
  - o_valid=1 for exactly one cycle, o_ready=0; next state IDLE.
  - Result registers update on the DONE entry edge and hold until the next DONE or reset.
- Result rules, normal case:
  - If quotient[N-1:WIDTH] != 0: o_quotient = all ones, o_overflow=1.
  - Otherwise: o_quotient = quotient[WIDTH-1:0], o_overflow=0.
  - o_remainder = final rem[WIDTH-1:0].
  - o_div_by_zero=0.
- Result rules, zero divisor:
  - o_quotient = all ones, o_remainder=0, o_div_by_zero=1, o_overflow=0.
- Latency, counting the accept cycle as cycle 0:
  - Normal: o_valid in cycle N+1, o_ready back to 1 in cycle N+2.
  - Zero divisor: o_valid in cycle 1, o_ready back to 1 in cycle 2.
- i_start while o_ready=0 (BUSY or DONE) is ignored; it is neither queued nor does it disturb the in-flight operands.
- Operand inputs may change freely after accept; only the latched copies are used.
- Dividend 0 gives quotient 0, remainder 0, no flags, with full latency N+1.

Test Plan:
- Defaults (WIDTH=8, FRAC=4, N=12).
  - Reset, then start with dividend 0x30 (3.0) and divisor 0x20 (2.0).
  - Required: o_valid in cycle 13 only; o_quotient=0x18 (1.5); o_remainder=0x00; both flags 0; o_ready=1 in cycle 14.
- Dividend 0x10 (1.0), divisor 0x30 (3.0).
  - Required: o_quotient=0x05 (0.3125); o_remainder=0x10; flags 0.
- Dividend 0xFF (15.9375), divisor 0x01 (0.0625).
  - True quotient is 0xFF0.
  - Required: o_quotient=0xFF; o_overflow=1; o_remainder=0x00; o_div_by_zero=0.
- Dividend 0x40, divisor 0x00.
  - Required: o_valid in cycle 1; o_quotient=0xFF; o_remainder=0; o_div_by_zero=1; o_overflow=0; o_ready=1 in cycle 2.
- Start 0x30/0x20, then in cycle 4 assert i_start with 0x10/0x30 and change the input buses.
  - Required: single o_valid in cycle 13 with o_quotient=0x18; no second o_valid.
- Start 0x30/0x20, then assert i_reset in cycle 5.
  - Required: cycle 6 has o_ready=1, o_valid=0 and all outputs 0; no o_valid ever appears for the aborted operation.
  - A fresh start 0x10/0x30 still yields 0x05/0x10.
